// File: rtl/alu_ctrl_md_if.sv
// Handshake and operand bundle between the EX stage and the multiply/divide engine.
// The master side issues operands and consumes results; the slave side is the engine.
interface alu_ctrl_md_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] md_result;
    logic            busy;

    modport master (
        output rs1, rs2, in_valid, flush, out_ready,
        input  in_ready, out_valid, md_result, busy
    );

    modport slave (
        input  rs1, rs2, in_valid, flush, out_ready,
        output in_ready, out_valid, md_result, busy
    );
endinterface

// File: rtl/alu_ctrl_md.sv
// Execute-stage ALU control decoder plus a sequential RV32M/RV64M multiply/divide engine.
// Operands are reduced to magnitudes on accept; signs are reapplied when the result is registered.
module alu_ctrl_md #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alu_op,
    input  logic       op5,
    input  logic       func7_5,
    input  logic       func7_0,
    input  logic [2:0] func3,
    output logic [4:0] alu_ctrl,
    output logic       md_sel,
    alu_ctrl_md_if.slave md
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_r, state_nx_s;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        func3_r;
    logic              negq_r, negr_r;
    logic [XLEN-1:0]   opa_r;
    logic [2*XLEN-1:0] prod_r;
    logic [XLEN:0]     rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   result_r;
    logic              out_valid_r;

    logic              accept_s, last_s;
    logic              sgn1_s, sgn2_s, neg1_s, neg2_s;
    logic [XLEN-1:0]   mag1_s, mag2_s;
    logic              div_zero_s, ovf_s;
    logic [2*XLEN-1:0] fast_prod_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] prod_nx_s;
    logic [XLEN:0]     div_shift_s, rem_nx_s;
    logic [XLEN-1:0]   quo_nx_s;

    function automatic logic [XLEN-1:0] mul_fin(input logic [2*XLEN-1:0] p,
                                                input logic neg, input logic [2:0] f3);
        logic [2*XLEN-1:0] pn;
        pn = neg ? -p : p;
        return (f3 == 3'b000) ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN];
    endfunction

    // Non-restoring remainder may end negative; one add of the divisor fixes it.
    function automatic logic [XLEN-1:0] div_fin(input logic [XLEN-1:0] q, input logic [XLEN:0] r,
                                                input logic [XLEN-1:0] d, input logic nq,
                                                input logic nr, input logic [2:0] f3);
        logic [XLEN-1:0] rf;
        rf = r[XLEN-1:0] + (r[XLEN] ? d : {XLEN{1'b0}});
        if (f3[1]) begin
            return nr ? -rf : rf;
        end
        return nq ? -q : q;
    endfunction

    // Main ALU control decode, independent of engine state.
    always_comb begin
        alu_ctrl = {alu_op[2], func7_5, func3};
        case (alu_op)
            3'b000: alu_ctrl = 5'b00000;
            3'b010: begin
                if (op5 && (func3 == 3'b000)) begin
                    alu_ctrl = func7_5 ? 5'b01000 : 5'b00000;
                end else begin
                    alu_ctrl = {alu_op[2], func7_5, func3};
                end
            end
            3'b011: begin
                if (!op5 && (func3 == 3'b000)) begin
                    alu_ctrl = 5'b00000;
                end else begin
                    alu_ctrl = {alu_op[2], func7_5, func3};
                end
            end
            default: alu_ctrl = {alu_op[2], func7_5, func3};
        endcase
    end

    assign md_sel   = (alu_op == 3'b010) & op5 & func7_0 & ~func7_5;
    assign accept_s = (state_r == S_IDLE) & md.in_valid & md_sel & ~md.flush;
    assign last_s   = (cnt_r == CW'(XLEN - 1));

    // Signedness per funct3: MUL is treated as signed since its low half is sign-agnostic.
    assign sgn1_s      = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    assign sgn2_s      = func3[2] ? ~func3[0] : ~func3[1];
    assign neg1_s      = sgn1_s & md.rs1[XLEN-1];
    assign neg2_s      = sgn2_s & md.rs2[XLEN-1];
    assign mag1_s      = neg1_s ? -md.rs1 : md.rs1;
    assign mag2_s      = neg2_s ? -md.rs2 : md.rs2;
    assign div_zero_s  = (md.rs2 == {XLEN{1'b0}});
    assign ovf_s       = ~func3[0] & (md.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (md.rs2 == {XLEN{1'b1}});
    assign fast_prod_s = {{XLEN{1'b0}}, mag1_s} * {{XLEN{1'b0}}, mag2_s};

    assign mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, opa_r} : {(XLEN+1){1'b0}});
    assign prod_nx_s   = {mul_sum_s, prod_r[XLEN-1:1]};
    assign div_shift_s = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
    assign rem_nx_s    = rem_r[XLEN] ? (div_shift_s + {1'b0, opa_r}) : (div_shift_s - {1'b0, opa_r});
    assign quo_nx_s    = {quo_r[XLEN-2:0], ~rem_nx_s[XLEN]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (!func3[2]) begin
                        state_nx_s = FAST_MUL ? S_DONE : S_MUL;
                    end else if (div_zero_s || ovf_s) begin
                        state_nx_s = S_DONE;
                    end else begin
                        state_nx_s = S_DIV;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_MUL:   state_nx_s = last_s ? S_DONE : S_MUL;
            S_DIV:   state_nx_s = last_s ? S_DONE : S_DIV;
            S_DONE:  state_nx_s = md.out_ready ? S_IDLE : S_DONE;
            default: state_nx_s = S_IDLE;
        endcase
        if (md.flush) begin
            state_nx_s = S_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // Operand capture, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            func3_r     <= 3'b000;
            negq_r      <= 1'b0;
            negr_r      <= 1'b0;
            opa_r       <= {XLEN{1'b0}};
            prod_r      <= {(2*XLEN){1'b0}};
            rem_r       <= {(XLEN+1){1'b0}};
            quo_r       <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_nx_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= {CW{1'b0}};
                        func3_r <= func3;
                        negq_r  <= neg1_s ^ neg2_s;
                        negr_r  <= neg1_s;
                        opa_r   <= func3[2] ? mag2_s : mag1_s;
                        prod_r  <= {{XLEN{1'b0}}, mag2_s};
                        rem_r   <= {(XLEN+1){1'b0}};
                        quo_r   <= mag1_s;
                        if (!func3[2]) begin
                            if (FAST_MUL) begin
                                result_r <= mul_fin(fast_prod_s, neg1_s ^ neg2_s, func3);
                            end
                        end else if (div_zero_s) begin
                            result_r <= func3[1] ? md.rs1 : {XLEN{1'b1}};
                        end else if (ovf_s) begin
                            result_r <= func3[1] ? {XLEN{1'b0}} : md.rs1;
                        end
                    end
                end
                S_MUL: begin
                    prod_r <= prod_nx_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        result_r <= mul_fin(prod_nx_s, negq_r, func3_r);
                    end
                end
                S_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        result_r <= div_fin(quo_nx_s, rem_nx_s, opa_r, negq_r, negr_r, func3_r);
                    end
                end
                S_DONE:  result_r <= result_r;
                default: cnt_r <= {CW{1'b0}};
            endcase
        end
    end

    assign md.in_ready  = (state_r == S_IDLE);
    assign md.busy      = (state_r != S_IDLE);
    assign md.out_valid = out_valid_r;
    assign md.md_result = result_r;
endmodule
